// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and helpers for the LEGv8 register file
//                with busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int                  REG_ADDR_W = 5;
    localparam int                  NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;
    localparam int                  BUSY_CNT_W = 6;
    localparam int                  NUM_STORED = NUM_REGS - 1;

    // A strobe only counts when it targets a real register (not XZR).
    function automatic logic addr_live(input logic en, input logic [REG_ADDR_W-1:0] addr);
        return en && (addr != ZERO_REG);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
//  Module      : regfile_read_port
//  Description : 32:1 read select with XZR override and optional same-cycle
//                write bypass (macro REGFILE_BYPASS_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [NUM_REGS-1:0][N-1:0]  i_regs,
    input  logic [NUM_REGS-1:0]         i_busy,
    input  logic [REG_ADDR_W-1:0]       i_addr,
    input  logic                        i_wr_live,
    input  logic [REG_ADDR_W-1:0]       i_wr_addr,
    input  logic [N-1:0]                i_wr_data,
    input  logic                        i_rsv_live,
    input  logic [REG_ADDR_W-1:0]       i_rsv_addr,
    output logic [N-1:0]                o_data,
    output logic                        o_busy
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        o_data = '0;
        o_busy = 1'b0;
        if (i_addr != ZERO_REG) begin
            o_data = i_regs[i_addr];
            o_busy = i_busy[i_addr];
        end
        // Live write wins; busy survives only if the same register is re-reserved.
        if (i_wr_live && (i_wr_addr == i_addr)) begin
            o_data = i_wr_data;
            o_busy = i_rsv_live && (i_rsv_addr == i_addr);
        end
    end
`else
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_wr_live, i_wr_addr, i_wr_data, i_rsv_live, i_rsv_addr};

    always_comb begin
        o_data = '0;
        o_busy = 1'b0;
        if (i_addr != ZERO_REG) begin
            o_data = i_regs[i_addr];
            o_busy = i_busy[i_addr];
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : 32 x N register file (XZR at 31) with two async read ports,
//                one write port and a per-register busy scoreboard.
//                Optional read bypass: macro REGFILE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int N = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REG_ADDR_W-1:0]   ReadReg1,
    input  logic [REG_ADDR_W-1:0]   ReadReg2,
    output logic [N-1:0]            ReadData1,
    output logic [N-1:0]            ReadData2,
    output logic                    Busy1,
    output logic                    Busy2,
    input  logic                    RegWrite,
    input  logic [REG_ADDR_W-1:0]   WriteReg,
    input  logic [N-1:0]            WriteData,
    input  logic                    Reserve,
    input  logic [REG_ADDR_W-1:0]   ReserveReg,
    output logic [BUSY_CNT_W-1:0]   BusyCount
);

    logic [NUM_STORED-1:0][N-1:0]   regs_q, regs_d;
    logic [NUM_STORED-1:0]          busy_q, busy_d;
    logic [BUSY_CNT_W-1:0]          busy_count_q, busy_count_d;

    logic                           w_wr_live;
    logic                           w_rsv_live;
    logic                           w_set;
    logic                           w_clr;
    logic [NUM_REGS-1:0][N-1:0]     w_regs_view;
    logic [NUM_REGS-1:0]            w_busy_view;

    // Strobes are masked in reset so a bypassed read cannot leak WriteData.
    assign w_wr_live  = rst_n && addr_live(RegWrite, WriteReg);
    assign w_rsv_live = rst_n && addr_live(Reserve, ReserveReg);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        w_set  = 1'b0;
        w_clr  = 1'b0;
        for (int i = 0; i < NUM_STORED; i++) begin
            if (w_wr_live && (WriteReg == REG_ADDR_W'(i))) begin
                regs_d[i] = WriteData;
                busy_d[i] = 1'b0;
            end
            // Reserve applied after write: the newer producer keeps the bit set.
            if (w_rsv_live && (ReserveReg == REG_ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
            w_set = w_set | (busy_d[i] & ~busy_q[i]);
            w_clr = w_clr | (~busy_d[i] & busy_q[i]);
        end
        busy_count_d = busy_count_q + BUSY_CNT_W'(w_set) - BUSY_CNT_W'(w_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q       <= '0;
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign w_regs_view = {{N{1'b0}}, regs_q};
    assign w_busy_view = {1'b0, busy_q};
    assign BusyCount   = busy_count_q;

    regfile_read_port #(.N(N)) u_read_port1 (
        .i_regs     (w_regs_view),
        .i_busy     (w_busy_view),
        .i_addr     (ReadReg1),
        .i_wr_live  (w_wr_live),
        .i_wr_addr  (WriteReg),
        .i_wr_data  (WriteData),
        .i_rsv_live (w_rsv_live),
        .i_rsv_addr (ReserveReg),
        .o_data     (ReadData1),
        .o_busy     (Busy1)
    );

    regfile_read_port #(.N(N)) u_read_port2 (
        .i_regs     (w_regs_view),
        .i_busy     (w_busy_view),
        .i_addr     (ReadReg2),
        .i_wr_live  (w_wr_live),
        .i_wr_addr  (WriteReg),
        .i_wr_data  (WriteData),
        .i_rsv_live (w_rsv_live),
        .i_rsv_addr (ReserveReg),
        .o_data     (ReadData2),
        .o_busy     (Busy2)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed scoreboard bench for regfile_scoreboard; expected
//                values also cover the REGFILE_BYPASS_EN build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    localparam int N = 64;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4:0]     ReadReg1, ReadReg2, WriteReg, ReserveReg;
    logic [N-1:0]   ReadData1, ReadData2, WriteData;
    logic           Busy1, Busy2, RegWrite, Reserve;
    logic [5:0]     BusyCount;

    regfile_scoreboard #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .Busy1      (Busy1),
        .Busy2      (Busy2),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .Reserve    (Reserve),
        .ReserveReg (ReserveReg),
        .BusyCount  (BusyCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        nm;
        logic [N-1:0] d1;
        logic [N-1:0] d2;
        logic         b1;
        logic         b2;
        logic [5:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input string field, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge and queue the outputs
    // expected for that same cycle (state before the following edge).
    task automatic step(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                        input logic we, input logic [4:0] wa, input logic [N-1:0] wd,
                        input logic rs, input logic [4:0] ra,
                        input logic [N-1:0] e1, input logic [N-1:0] e2,
                        input logic eb1, input logic eb2, input logic [5:0] ec,
                        input string nm);
        @(posedge clk);
        #1;
        rst_n      = rst;
        ReadReg1   = r1;
        ReadReg2   = r2;
        RegWrite   = we;
        WriteReg   = wa;
        WriteData  = wd;
        Reserve    = rs;
        ReserveReg = ra;
        exp_q.push_back('{nm, e1, e2, eb1, eb2, ec});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.nm, "ReadData1", ReadData1, e.d1);
                chk(e.nm, "ReadData2", ReadData2, e.d2);
                chk(e.nm, "Busy1",     {63'd0, Busy1}, {63'd0, e.b1});
                chk(e.nm, "Busy2",     {63'd0, Busy2}, {63'd0, e.b2});
                chk(e.nm, "BusyCount", {58'd0, BusyCount}, {58'd0, e.cnt});
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        ReadReg1 = '0; ReadReg2 = '0; RegWrite = 1'b0; WriteReg = '0;
        WriteData = '0; Reserve = 1'b0; ReserveReg = '0;

        //   rst r1  r2  we wa  wd                      rs ra   ReadData1 / ReadData2 expected            b1 b2 cnt
        step(0, 0,  0,  0, 0,  64'h0,                  0, 0,   64'h0, 64'h0,                             0, 0, 0, "reset");
        step(1, 5,  31, 1, 5,  64'hDEAD_BEEF_0000_0001, 0, 0,  BYP ? 64'hDEAD_BEEF_0000_0001 : 64'h0, 64'h0, 0, 0, 0, "wr5_issue");
        step(1, 5,  31, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,  64'hDEAD_BEEF_0000_0001, 64'h0,           0, 0, 0, "rd5_wr31");
        step(1, 31, 31, 0, 0,  64'h0,                  0, 0,   64'h0, 64'h0,                             0, 0, 0, "rd31_both");
        step(1, 3,  7,  0, 0,  64'h0,                  1, 3,   64'h0, 64'h0,                             0, 0, 0, "rsv3_issue");
        step(1, 3,  7,  0, 0,  64'h0,                  1, 3,   64'h0, 64'h0,                             1, 0, 1, "rsv3_seen");
        step(1, 3,  7,  0, 0,  64'h0,                  1, 7,   64'h0, 64'h0,                             1, 0, 1, "rsv3_again");
        step(1, 3,  7,  1, 3,  64'h33,                 0, 0,   BYP ? 64'h33 : 64'h0, 64'h0,              !BYP, 1, 2, "rsv7_seen");
        step(1, 3,  7,  0, 0,  64'h0,                  1, 9,   64'h33, 64'h0,                            0, 1, 1, "wr3_seen");
        step(1, 9,  3,  1, 9,  64'h99,                 1, 9,   BYP ? 64'h99 : 64'h0, 64'h33,             1, 0, 2, "wr_rsv9_issue");
        step(1, 9,  12, 1, 12, 64'h1234,               0, 0,   64'h99, BYP ? 64'h1234 : 64'h0,           1, 0, 2, "wr12_issue");
        step(1, 12, 9,  1, 7,  64'h77,                 1, 12,  64'h1234, 64'h99,                         0, 1, 2, "wr12_seen");
        step(1, 7,  12, 1, 5,  64'hAA,                 0, 0,   64'h77, 64'h1234,                         0, 1, 2, "wr7_rsv12_seen");
        step(1, 5,  9,  1, 9,  64'h1,                  0, 0,   64'hAA, BYP ? 64'h1 : 64'h99,             0, !BYP, 2, "wr5_nonbusy");
        step(1, 9,  12, 0, 0,  64'h0,                  1, 31,  64'h1, 64'h1234,                          0, 1, 1, "wr9_clear");
        step(1, 9,  12, 0, 0,  64'h0,                  0, 0,   64'h1, 64'h1234,                          0, 1, 1, "rsv31_ignored");
        step(0, 9,  12, 1, 9,  64'h55,                 1, 3,   64'h0, 64'h0,                             0, 0, 0, "reset_mid");
        step(1, 9,  12, 0, 0,  64'h0,                  0, 0,   64'h0, 64'h0,                             0, 0, 0, "post_reset");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
